// File: rtl/z80_mem_cycle_ctrl_pkg.sv
// z80_bus_pkg: shared state encodings and defaults for the Z80 memory cycle controller
package z80_bus_pkg;
  typedef enum logic {BOOT, RUN} boot_state_t;
  typedef enum logic [1:0] {IDLE, ACTIVE, HOLD} cyc_state_t;
  localparam logic [3:0] ROM_NIBBLE_DEF = 4'hF;
endpackage

// File: rtl/z80_mem_cycle_ctrl_if.sv
// z80_mem_cycle_ctrl_if: raw Z80 strobes in, decoder-side memory cycle signals out
interface z80_mem_cycle_ctrl_if;
  logic mreq_n, rd_n, wr_n, m1_n, rfsh_n;
  logic [3:0] cpu_adr, dec_adr;
  logic memread, memwrite, reset_cs, boot, wait_n;
  modport master (
    output mreq_n, rd_n, wr_n, m1_n, rfsh_n, cpu_adr,
    input dec_adr, memread, memwrite, reset_cs, boot, wait_n
  );
  modport slave (
    input mreq_n, rd_n, wr_n, m1_n, rfsh_n, cpu_adr,
    output dec_adr, memread, memwrite, reset_cs, boot, wait_n
  );
endinterface

// File: rtl/z80_mem_cycle_ctrl_sync2.sv
// sync2: two-flop synchroniser for an asynchronous active-low strobe, idles high
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk or posedge rst)
    if (rst) {q, m} <= 2'b11;
    else {q, m} <= {m, d};
endmodule

// File: rtl/z80_mem_cycle_ctrl.sv
// z80_mem_cycle_ctrl: clean memread/memwrite from Z80 strobes, boot phantom chip select and ROM wait states
module z80_mem_cycle_ctrl
  import z80_bus_pkg::*;
#(
  parameter int ROM_WAIT = 1,
  parameter logic [3:0] ROM_NIBBLE = ROM_NIBBLE_DEF
) (
  input logic clock,
  input logic reset,
  z80_mem_cycle_ctrl_if.slave bus
);
  localparam int WW = ROM_WAIT < 1 ? 1 : $clog2(ROM_WAIT + 1);
  logic mreq_s, rd_s, wr_s, m1_s, rfsh_s, rd_act, wr_act, rom_rd;
  logic arm, arm_d, rd_q, rd_d, wr_q, wr_d, wait_q, wait_d;
  logic [WW-1:0] wcnt, wcnt_d;
  logic [3:0] adr_q, adr_d, eff;
  cyc_state_t cs, cs_d;
  boot_state_t bs, bs_d;
  sync2 u_mreq (.clk(clock), .rst(reset), .d(bus.mreq_n), .q(mreq_s));
  sync2 u_rd   (.clk(clock), .rst(reset), .d(bus.rd_n),   .q(rd_s));
  sync2 u_wr   (.clk(clock), .rst(reset), .d(bus.wr_n),   .q(wr_s));
  sync2 u_m1   (.clk(clock), .rst(reset), .d(bus.m1_n),   .q(m1_s));
  sync2 u_rfsh (.clk(clock), .rst(reset), .d(bus.rfsh_n), .q(rfsh_s));
  // rd and wr low together is illegal, so neither strobe qualifies
  assign rd_act = !mreq_s && !rd_s && wr_s && rfsh_s;
  assign wr_act = !mreq_s && !wr_s && rd_s;
  assign eff = bs == BOOT ? ROM_NIBBLE : bus.cpu_adr;
  assign rom_rd = rd_act && eff == ROM_NIBBLE;
  always_comb begin
    cs_d = cs;
    bs_d = bs;
    adr_d = adr_q;
    arm_d = arm;
    wcnt_d = wcnt;
    rd_d = rd_q;
    wr_d = wr_q;
    wait_d = wait_q;
    case (cs)
      IDLE: if (rd_act || wr_act) begin
        cs_d = ACTIVE;
        adr_d = bus.cpu_adr;
        rd_d = rd_act;
        wr_d = wr_act;
        arm_d = rd_act && !m1_s && bus.cpu_adr == ROM_NIBBLE;
        wcnt_d = rom_rd ? WW'(ROM_WAIT) : '0;
        wait_d = wcnt_d == '0;
      end
      ACTIVE: if (!rd_act && !wr_act) begin
        cs_d = IDLE;
        rd_d = 1'b0;
        wr_d = 1'b0;
        wait_d = 1'b1;
      end else if (wcnt != '0) begin
        wcnt_d = wcnt - WW'(1);
        wait_d = wcnt_d == '0;
      end else begin
        cs_d = HOLD;
        wait_d = 1'b1;
      end
      HOLD: if (!rd_act && !wr_act) begin
        cs_d = IDLE;
        rd_d = 1'b0;
        wr_d = 1'b0;
        bs_d = arm ? RUN : bs;
      end
      default: cs_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      cs <= IDLE;
      bs <= BOOT;
      adr_q <= '0;
      arm <= 1'b0;
      wcnt <= '0;
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      wait_q <= 1'b1;
    end else begin
      cs <= cs_d;
      bs <= bs_d;
      adr_q <= adr_d;
      arm <= arm_d;
      wcnt <= wcnt_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      wait_q <= wait_d;
    end
  assign bus.memread = rd_q;
  assign bus.memwrite = wr_q;
  assign bus.wait_n = wait_q;
  assign bus.boot = bs == BOOT;
  assign bus.reset_cs = bs == RUN;
  assign bus.dec_adr = bs == BOOT ? ROM_NIBBLE : adr_q;
endmodule

// File: tb/tb_z80_mem_cycle_ctrl.sv
// tb_z80_mem_cycle_ctrl: scoreboarded random Z80 memory cycles against a boot/wait reference model
module tb_z80_mem_cycle_ctrl;
  typedef struct {
    bit rd;
    logic [3:0] dec;
    int wclk;
    bit boot;
    bit boot_after;
    int rise;
    int fall;
  } item_t;
  localparam int W0 = 1, W1 = 3;
  logic clock = 0, reset = 0;
  logic mreq_n = 1, rd_n = 1, wr_n = 1, m1_n = 1, rfsh_n = 1;
  logic [3:0] cpu_adr = '0;
  int cyc = 0, n_cmp = 0, n_bad = 0;
  bit mboot = 1;
  item_t q0[$], q1[$], cur[2];
  bit busy[2], dec_moved[2];
  int wl[2];
  logic [1:0] mr, mw, wn, bt, rc;
  logic [3:0] da[2];

  z80_mem_cycle_ctrl_if b0(), b1();
  assign b0.mreq_n = mreq_n;
  assign b0.rd_n = rd_n;
  assign b0.wr_n = wr_n;
  assign b0.m1_n = m1_n;
  assign b0.rfsh_n = rfsh_n;
  assign b0.cpu_adr = cpu_adr;
  assign b1.mreq_n = mreq_n;
  assign b1.rd_n = rd_n;
  assign b1.wr_n = wr_n;
  assign b1.m1_n = m1_n;
  assign b1.rfsh_n = rfsh_n;
  assign b1.cpu_adr = cpu_adr;
  assign mr = {b1.memread, b0.memread};
  assign mw = {b1.memwrite, b0.memwrite};
  assign wn = {b1.wait_n, b0.wait_n};
  assign bt = {b1.boot, b0.boot};
  assign rc = {b1.reset_cs, b0.reset_cs};
  assign da[0] = b0.dec_adr;
  assign da[1] = b1.dec_adr;

  z80_mem_cycle_ctrl #(.ROM_WAIT(W0)) dut0 (.clock(clock), .reset(reset), .bus(b0.slave));
  z80_mem_cycle_ctrl #(.ROM_WAIT(W1)) dut1 (.clock(clock), .reset(reset), .bus(b1.slave));

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic void chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // monitor: one scoreboard entry per memread/memwrite pulse on each instance
  always @(negedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) busy[i] = 0;
      else if (mr[i] || mw[i]) begin
        if (!busy[i]) begin
          int sz;
          sz = i ? q1.size() : q0.size();
          chk($sformatf("cycle_expected[%0d]", i), int'(sz > 0), 1);
          if (sz > 0) begin
            if (i) cur[i] = q1.pop_front();
            else cur[i] = q0.pop_front();
            busy[i] = 1;
            wl[i] = 0;
            dec_moved[i] = 0;
            chk($sformatf("rise_cycle[%0d]", i), cyc, cur[i].rise);
            chk($sformatf("memread[%0d]", i), mr[i], cur[i].rd);
            chk($sformatf("memwrite[%0d]", i), mw[i], !cur[i].rd);
            chk($sformatf("dec_adr[%0d]", i), da[i], cur[i].dec);
            chk($sformatf("boot[%0d]", i), bt[i], cur[i].boot);
            chk($sformatf("reset_cs[%0d]", i), rc[i], !cur[i].boot);
          end
        end
        if (busy[i]) begin
          if (!wn[i]) wl[i]++;
          if (da[i] != cur[i].dec) dec_moved[i] = 1;
        end
      end else if (busy[i]) begin
        busy[i] = 0;
        chk($sformatf("fall_cycle[%0d]", i), cyc, cur[i].fall);
        chk($sformatf("wait_clocks[%0d]", i), wl[i], cur[i].wclk);
        chk($sformatf("dec_stable[%0d]", i), dec_moved[i], 0);
        chk($sformatf("boot_after[%0d]", i), bt[i], cur[i].boot_after);
        chk($sformatf("reset_cs_after[%0d]", i), rc[i], !cur[i].boot_after);
        chk($sformatf("wait_idle[%0d]", i), wn[i], 1);
      end
    end
  end

  task automatic txn(bit rd, bit m1, logic [3:0] a);
    item_t it;
    int h;
    logic [3:0] eff;
    eff = mboot ? 4'hF : a;
    h = 6 + $urandom_range(0, 4);
    it.rd = rd;
    it.dec = eff;
    it.boot = mboot;
    it.boot_after = mboot && !(rd && m1 && a == 4'hF);
    it.rise = cyc + 3;
    it.fall = cyc + h + 3;
    it.wclk = (rd && eff == 4'hF) ? W0 : 0;
    q0.push_back(it);
    it.wclk = (rd && eff == 4'hF) ? W1 : 0;
    q1.push_back(it);
    mboot = it.boot_after;
    cpu_adr = a;
    m1_n = !m1;
    mreq_n = 0;
    if (rd) rd_n = 0;
    else wr_n = 0;
    repeat (4) tick();
    cpu_adr = 4'($urandom);
    repeat (h - 4) tick();
    mreq_n = 1;
    rd_n = 1;
    wr_n = 1;
    m1_n = 1;
    repeat (2 + $urandom_range(0, 2)) tick();
  endtask

  task automatic random_txn();
    bit rd, m1;
    logic [3:0] a;
    rd = 1'($urandom_range(0, 1));
    m1 = rd && $urandom_range(0, 3) == 0;
    a = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
    txn(rd, m1, a);
  endtask

  task automatic nocycle(bit illegal);
    bit seen;
    seen = 0;
    mreq_n = 0;
    rd_n = 0;
    if (illegal) wr_n = 0;
    else rfsh_n = 0;
    repeat (8) begin
      tick();
      if (mr != 0 || mw != 0) seen = 1;
    end
    chk(illegal ? "illegal_rd_wr" : "refresh_ignored", seen, 0);
    mreq_n = 1;
    rd_n = 1;
    wr_n = 1;
    rfsh_n = 1;
    repeat (4) tick();
  endtask

  initial begin
    bit found, done;
    #1 reset = 1;
    #2;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_memread[%0d]", i), mr[i], 0);
      chk($sformatf("rst_memwrite[%0d]", i), mw[i], 0);
      chk($sformatf("rst_wait_n[%0d]", i), wn[i], 1);
      chk($sformatf("rst_reset_cs[%0d]", i), rc[i], 0);
      chk($sformatf("rst_boot[%0d]", i), bt[i], 1);
      chk($sformatf("rst_dec_adr[%0d]", i), da[i], 4'hF);
    end
    repeat (3) tick();
    reset = 0;
    tick();
    txn(1, 1, 4'h0);
    txn(1, 0, 4'hF);
    txn(0, 0, 4'hF);
    nocycle(0);
    nocycle(1);
    txn(1, 1, 4'hF);
    txn(1, 0, 4'h1);
    txn(0, 0, 4'hE);
    txn(1, 0, 4'hF);
    repeat (30) random_txn();
    // reset while the slow instance is stretching a ROM read
    cpu_adr = 4'hF;
    mreq_n = 0;
    rd_n = 0;
    found = 0;
    for (int t = 0; t < 10 && !found; t++) begin
      tick();
      found = wn[1] == 0;
    end
    chk("mid_wait_seen", found, 1);
    #2 reset = 1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("mid_rst_memread[%0d]", i), mr[i], 0);
      chk($sformatf("mid_rst_wait_n[%0d]", i), wn[i], 1);
      chk($sformatf("mid_rst_reset_cs[%0d]", i), rc[i], 0);
      chk($sformatf("mid_rst_boot[%0d]", i), bt[i], 1);
      chk($sformatf("mid_rst_dec_adr[%0d]", i), da[i], 4'hF);
    end
    mreq_n = 1;
    rd_n = 1;
    q0.delete();
    q1.delete();
    mboot = 1;
    repeat (3) tick();
    reset = 0;
    repeat (2) tick();
    txn(1, 1, 4'h0);
    repeat (12) random_txn();
    done = 0;
    for (int t = 0; t < 60 && !done; t++) begin
      tick();
      done = q0.size() == 0 && q1.size() == 0 && !busy[0] && !busy[1];
    end
    chk("drain", done, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
